// File: rtl/mmu_pkg.sv
// Shared types and defaults for the mmu stimulus feeder.
// Holds array geometry, the feeder state enum and lane slicing helpers.
package mmu_pkg;

  localparam int MMU_N  = 4;
  localparam int MMU_DW = 8;
  localparam int MMU_MSB_LANE = MMU_N - 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    PUSH_W,
    GAP,
    STREAM,
    DRAIN
  } state_t;

  function automatic int lane_lo(input int b, input int dw);
    return b * dw;
  endfunction

endpackage

// File: rtl/mmu_skew_line.sv
// Fixed-depth delay line for one data lane of the skew network.
// Depth 0 is a plain wire; the lane output register lives in the top.
module mmu_skew_line #(
  parameter int D = 0,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (D == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = clk ^ rst_n;
      assign dout = din;
    end else begin : g_dly
      logic [W-1:0] sr [D];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else begin
          sr[0] <= din;
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign dout = sr[D-1];
    end
  endgenerate

endmodule

// File: rtl/mmu_feeder.sv
// Weight load sequencer and data skewer feeding the systolic mmu.
// Define MMU_FEEDER_STATS_EN to add rows_cnt / bubble_cnt outputs.
module mmu_feeder
  import mmu_pkg::*;
#(
  parameter int N  = MMU_N,
  parameter int DW = MMU_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N*DW-1:0] wt_in,
  input  logic          wt_valid,
  output logic          wt_ready,
  input  logic [N*DW-1:0] data_in,
  input  logic          data_valid,
  input  logic          data_last,
  output logic          data_ready,
  output logic          control,
  output logic [N*DW-1:0] wt_arr,
  output logic [N*DW-1:0] data_arr,
  output logic          busy,
  output logic          done
`ifdef MMU_FEEDER_STATS_EN
  ,
  output logic [15:0]   rows_cnt,
  output logic [15:0]   bubble_cnt
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
  localparam logic [CW-1:0] LAST_DRN  = CW'(N - 2);

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N*DW-1:0] wbuf [N];
  logic [N*DW-1:0] skew_in, skew_out;
  logic done_pend;
  logic wt_fire, data_fire;

  assign wt_ready   = (state == LOAD_W);
  assign data_ready = (state == STREAM);
  assign busy       = (state != IDLE);
  assign wt_fire    = wt_valid & wt_ready;
  assign data_fire  = data_valid & data_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) state_n = LOAD_W;
      end
      LOAD_W: begin
        if (wt_fire) begin
          if (cnt == LAST_BEAT) begin
            state_n = PUSH_W;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      PUSH_W: begin
        if (cnt == LAST_BEAT) begin
          state_n = GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: state_n = STREAM;
      STREAM: begin
        if (data_fire && data_last) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end
      end
      DRAIN: begin
        if (cnt == LAST_DRN) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Bubbles enter the skew as zeros; the array cannot stall.
  assign skew_in = data_fire ? data_in : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      control   <= 1'b0;
      wt_arr    <= '0;
      data_arr  <= '0;
      done_pend <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      control   <= (state == PUSH_W);
      wt_arr    <= (state == PUSH_W) ? wbuf[cnt] : '0;
      data_arr  <= skew_out;
      done_pend <= (state == DRAIN) && (cnt == LAST_DRN);
      done      <= done_pend;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) wbuf[i] <= '0;
    end else if (wt_fire) begin
      wbuf[cnt] <= wt_in;
    end
  end

  for (genvar b = 0; b < N; b++) begin : g_lane
    mmu_skew_line #(
      .D(N - 1 - b),
      .W(DW)
    ) u_line (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (skew_in[lane_lo(b, DW) +: DW]),
      .dout (skew_out[lane_lo(b, DW) +: DW])
    );
  end

`ifdef MMU_FEEDER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows_cnt   <= '0;
      bubble_cnt <= '0;
    end else if (state == IDLE && start) begin
      rows_cnt   <= '0;
      bubble_cnt <= '0;
    end else begin
      if (data_fire && rows_cnt != 16'hFFFF)
        rows_cnt <= rows_cnt + 16'd1;
      if (state == STREAM && !data_valid && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule
